// File: rtl/mem_ctrl_arbiter_pkg.sv
// Shared types and constants for the byte-serial RAM port arbiter.
// Holds the FSM state encoding, access-length codes and the beat-count helper.
package mem_ctrl_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b11;

  localparam logic [2:0] BEATS_BYTE = 3'd1;
  localparam logic [2:0] BEATS_HALF = 3'd2;
  localparam logic [2:0] BEATS_WORD = 3'd4;

  // The illegal length code 2'b10 is served as a full word.
  function automatic logic [2:0] beat_count(input logic [1:0] len);
    case (len)
      LEN_BYTE: return BEATS_BYTE;
      LEN_HALF: return BEATS_HALF;
      LEN_WORD: return BEATS_WORD;
      default:  return BEATS_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// Shares the byte-wide RAM port between I-cache refill and MEM load/store,
// splitting each access into little-endian byte beats with stall-safe re-issue.
module mem_ctrl_arbiter
  import mem_ctrl_arbiter_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [1:0]        mem_len_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [ADDR_W-1:0] ram_a_out,
  output logic              ram_wr_out,
  output logic              if_done_out,
  output logic [31:0]       if_data_out,
  output logic              mem_done_out,
  output logic [31:0]       mem_data_out,
  output logic              mem_busy_out
);

  state_t            state_reg, state_next;
  logic [2:0]        iss_reg, iss_next;
  logic [2:0]        cap_reg, cap_next;
  logic [2:0]        nbeats_reg, nbeats_next;
  logic              v1_reg, v1_next;
  logic              v2_reg, v2_next;
  logic              stall_reg, stall_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [ADDR_W-1:0] ram_a_reg, ram_a_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       asm_reg, asm_next;
  logic [31:0]       if_data_reg, if_data_next;
  logic [31:0]       mem_data_reg, mem_data_next;
  logic [7:0]        ram_dout_reg, ram_dout_next;
  logic              ram_wr_reg, ram_wr_next;
  logic              if_done_reg, if_done_next;
  logic              mem_done_reg, mem_done_next;
  logic              mem_busy_reg, mem_busy_next;

  logic [31:0]       merged;
  logic [2:0]        iss_eff;
  logic [7:0]        wr_byte;

  // Byte lane cap takes the returning RAM byte; the other lanes keep what was assembled.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = (cap_reg[1:0] == 2'(gi)) ? ram_din_in : asm_reg[8*gi +: 8];
    end
  endgenerate

  assign wr_byte = wdata_reg[{iss_reg[1:0], 3'b000} +: 8];

  // After a stall the reads that were in flight are lost, so issuing restarts at the capture point.
  assign iss_eff = stall_reg ? cap_reg : iss_reg;

  always_comb begin
    state_next    = state_reg;
    iss_next      = iss_reg;
    cap_next      = cap_reg;
    nbeats_next   = nbeats_reg;
    v1_next       = v1_reg;
    v2_next       = v2_reg;
    stall_next    = stall_reg;
    base_next     = base_reg;
    ram_a_next    = ram_a_reg;
    wdata_next    = wdata_reg;
    asm_next      = asm_reg;
    if_data_next  = if_data_reg;
    mem_data_next = mem_data_reg;
    ram_dout_next = ram_dout_reg;
    ram_wr_next   = ram_wr_reg;
    if_done_next  = if_done_reg;
    mem_done_next = mem_done_reg;
    mem_busy_next = mem_busy_reg;

    if (!rdy_in) begin
      stall_next = 1'b1;
    end else begin
      stall_next = 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (mem_req_in) begin
            state_next    = mem_we_in ? ST_MEM_WR : ST_MEM_RD;
            base_next     = mem_addr_in;
            wdata_next    = mem_wdata_in;
            nbeats_next   = beat_count(mem_len_in);
            ram_a_next    = mem_addr_in;
            iss_next      = 3'd1;
            cap_next      = 3'd0;
            asm_next      = '0;
            v1_next       = !mem_we_in;
            v2_next       = 1'b0;
            mem_busy_next = 1'b1;
            if (mem_we_in) begin
              ram_wr_next   = 1'b1;
              ram_dout_next = mem_wdata_in[7:0];
            end
          end else if (if_req_in) begin
            state_next  = ST_IF_RD;
            base_next   = if_addr_in;
            nbeats_next = BEATS_WORD;
            ram_a_next  = if_addr_in;
            iss_next    = 3'd1;
            cap_next    = 3'd0;
            asm_next    = '0;
            v1_next     = 1'b1;
            v2_next     = 1'b0;
          end
        end

        ST_IF_RD, ST_MEM_RD: begin
          if (state_reg == ST_IF_RD && !if_req_in) begin
            state_next = ST_IDLE;
            v1_next    = 1'b0;
            v2_next    = 1'b0;
          end else begin
            v2_next = v1_reg && !stall_reg;
            if (iss_eff < nbeats_reg) begin
              ram_a_next = base_reg + ADDR_W'(iss_eff);
              iss_next   = iss_eff + 3'd1;
              v1_next    = 1'b1;
            end else begin
              iss_next = iss_eff;
              v1_next  = 1'b0;
            end
            if (v2_reg && !stall_reg) begin
              asm_next = merged;
              cap_next = cap_reg + 3'd1;
              if (cap_reg == nbeats_reg - 3'd1) begin
                state_next = ST_DONE;
                v1_next    = 1'b0;
                v2_next    = 1'b0;
                if (state_reg == ST_IF_RD) begin
                  if_done_next = 1'b1;
                  if_data_next = merged;
                end else begin
                  mem_done_next = 1'b1;
                  mem_data_next = merged;
                end
              end
            end
          end
        end

        ST_MEM_WR: begin
          // The beat presented during the last cycle was written at this edge.
          cap_next = cap_reg + 3'd1;
          if (cap_reg == nbeats_reg - 3'd1) begin
            ram_wr_next   = 1'b0;
            mem_done_next = 1'b1;
            state_next    = ST_DONE;
          end else begin
            ram_a_next    = base_reg + ADDR_W'(iss_reg);
            ram_dout_next = wr_byte;
            iss_next      = iss_reg + 3'd1;
          end
        end

        ST_DONE: begin
          state_next    = ST_IDLE;
          if_done_next  = 1'b0;
          mem_done_next = 1'b0;
          mem_busy_next = 1'b0;
        end

        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg    <= ST_IDLE;
      iss_reg      <= '0;
      cap_reg      <= '0;
      nbeats_reg   <= '0;
      v1_reg       <= 1'b0;
      v2_reg       <= 1'b0;
      stall_reg    <= 1'b0;
      base_reg     <= '0;
      ram_a_reg    <= '0;
      wdata_reg    <= '0;
      asm_reg      <= '0;
      if_data_reg  <= '0;
      mem_data_reg <= '0;
      ram_dout_reg <= '0;
      ram_wr_reg   <= 1'b0;
      if_done_reg  <= 1'b0;
      mem_done_reg <= 1'b0;
      mem_busy_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      iss_reg      <= iss_next;
      cap_reg      <= cap_next;
      nbeats_reg   <= nbeats_next;
      v1_reg       <= v1_next;
      v2_reg       <= v2_next;
      stall_reg    <= stall_next;
      base_reg     <= base_next;
      ram_a_reg    <= ram_a_next;
      wdata_reg    <= wdata_next;
      asm_reg      <= asm_next;
      if_data_reg  <= if_data_next;
      mem_data_reg <= mem_data_next;
      ram_dout_reg <= ram_dout_next;
      ram_wr_reg   <= ram_wr_next;
      if_done_reg  <= if_done_next;
      mem_done_reg <= mem_done_next;
      mem_busy_reg <= mem_busy_next;
    end
  end

  // A frozen write beat must not reach the RAM, so the strobe is gated by rdy.
  assign ram_wr_out   = ram_wr_reg && rdy_in;
  assign ram_a_out    = ram_a_reg;
  assign ram_dout_out = ram_dout_reg;
  assign if_done_out  = if_done_reg;
  assign if_data_out  = if_data_reg;
  assign mem_done_out = mem_done_reg;
  assign mem_data_out = mem_data_reg;
  assign mem_busy_out = mem_busy_reg;

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Directed bench for mem_ctrl_arbiter with a byte RAM that answers one cycle late.
// Each test drives one scenario and compares outputs against hand-derived values.
module tb_mem_ctrl_arbiter;
  localparam int ADDR_W = 18;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in;
  logic              if_req_in, mem_req_in, mem_we_in;
  logic [ADDR_W-1:0] if_addr_in, mem_addr_in;
  logic [1:0]        mem_len_in;
  logic [31:0]       mem_wdata_in;
  logic [7:0]        ram_din_in = 8'h00;
  logic [7:0]        ram_dout_out;
  logic [ADDR_W-1:0] ram_a_out;
  logic              ram_wr_out, if_done_out, mem_done_out, mem_busy_out;
  logic [31:0]       if_data_out, mem_data_out;

  mem_ctrl_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .mem_len_in(mem_len_in),
    .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in), .ram_din_in(ram_din_in),
    .ram_dout_out(ram_dout_out), .ram_a_out(ram_a_out), .ram_wr_out(ram_wr_out),
    .if_done_out(if_done_out), .if_data_out(if_data_out),
    .mem_done_out(mem_done_out), .mem_data_out(mem_data_out), .mem_busy_out(mem_busy_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int both_cnt = 0;
  int cyc;
  int wr0;
  logic [25:0] wr_log[$];

  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic              pk_en = 1'b0;
  logic [ADDR_W-1:0] pk_addr = '0;
  logic [7:0]        pk_data = 8'h00;

  always @(posedge clk_in) begin
    ram_din_in <= ram[ram_a_out];
    if (pk_en) ram[pk_addr] <= pk_data;
    else if (ram_wr_out) ram[ram_a_out] <= ram_dout_out;
  end

  always @(negedge clk_in) begin
    if (ram_wr_out) wr_log.push_back({ram_a_out, ram_dout_out});
    if (if_done_out && mem_done_out) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic poke4(input logic [ADDR_W-1:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      pk_en   = 1'b1;
      pk_addr = a + ADDR_W'(i);
      pk_data = w[8*i +: 8];
      tick();
    end
    pk_en = 1'b0;
  endtask

  task automatic wait_done(input bit on_mem, input int limit, output int c);
    int k;
    c = -1;
    k = 0;
    while (c < 0 && k < limit) begin
      tick();
      k++;
      if (on_mem ? mem_done_out : if_done_out) c = k;
    end
  endtask

  task automatic mem_cmd(input logic we, input logic [1:0] len, input logic [ADDR_W-1:0] a,
                         input logic [31:0] wd);
    mem_req_in   = 1'b1;
    mem_we_in    = we;
    mem_len_in   = len;
    mem_addr_in  = a;
    mem_wdata_in = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    if_req_in = 1'b0; if_addr_in = '0;
    mem_req_in = 1'b0; mem_we_in = 1'b0; mem_len_in = 2'b00;
    mem_addr_in = '0; mem_wdata_in = '0;
    tick(); tick();
    check("rst_ram_a", ram_a_out, 0);
    check("rst_ram_dout", ram_dout_out, 0);
    check("rst_ram_wr", ram_wr_out, 0);
    check("rst_if_done", if_done_out, 0);
    check("rst_if_data", if_data_out, 0);
    check("rst_mem_done", mem_done_out, 0);
    check("rst_mem_data", mem_data_out, 0);
    check("rst_busy", mem_busy_out, 0);
    rst_in = 1'b0;
    tick();

    poke4(18'h00100, 32'h00000013);
    poke4(18'h00104, 32'h12345678);
    poke4(18'h00004, 32'h80000000);

    // IF word read: done in the 6th cycle after grant, no writes
    wr0 = wr_log.size();
    if_req_in = 1'b1; if_addr_in = 18'h00100;
    tick();
    check("if_grant_addr", ram_a_out, 18'h00100);
    check("if_busy_low", mem_busy_out, 0);
    wait_done(1'b0, 8, cyc);
    check("if_done_cycle", cyc, 5);
    check("if_data", if_data_out, 32'h00000013);
    if_req_in = 1'b0;
    tick();
    check("if_done_one_cycle", if_done_out, 0);
    check("if_no_write", wr_log.size() - wr0, 0);

    // Word store: four write beats then done
    wr0 = wr_log.size();
    mem_cmd(1'b1, 2'b11, 18'h00200, 32'hDEADBEEF);
    tick();
    check("st_busy", mem_busy_out, 1);
    wait_done(1'b1, 8, cyc);
    check("st_done_cycle", cyc, 4);
    mem_req_in = 1'b0;
    tick();
    check("st_beats", wr_log.size() - wr0, 4);
    check("st_beat0", (wr_log.size() > wr0 + 0) ? 32'(wr_log[wr0 + 0]) : 32'hFFFFFFFF, {18'h00200, 8'hEF});
    check("st_beat1", (wr_log.size() > wr0 + 1) ? 32'(wr_log[wr0 + 1]) : 32'hFFFFFFFF, {18'h00201, 8'hBE});
    check("st_beat2", (wr_log.size() > wr0 + 2) ? 32'(wr_log[wr0 + 2]) : 32'hFFFFFFFF, {18'h00202, 8'hAD});
    check("st_beat3", (wr_log.size() > wr0 + 3) ? 32'(wr_log[wr0 + 3]) : 32'hFFFFFFFF, {18'h00203, 8'hDE});

    // Simultaneous requests: MEM byte load first, then the IF read
    if_req_in = 1'b1; if_addr_in = 18'h00100;
    mem_cmd(1'b0, 2'b00, 18'h00007, 32'h0);
    tick();
    check("pri_busy", mem_busy_out, 1);
    check("pri_addr", ram_a_out, 18'h00007);
    wait_done(1'b1, 6, cyc);
    check("pri_done_cycle", cyc, 2);
    check("pri_data", mem_data_out, 32'h00000080);
    check("pri_busy_in_done", mem_busy_out, 1);
    check("pri_no_if_done", if_done_out, 0);
    mem_req_in = 1'b0;
    tick();
    check("pri_busy_fall", mem_busy_out, 0);
    tick();
    check("pri_if_grant", ram_a_out, 18'h00100);
    wait_done(1'b0, 8, cyc);
    check("pri_if_cycle", cyc, 5);
    check("pri_if_data", if_data_out, 32'h00000013);
    if_req_in = 1'b0;
    tick();

    // IF abort after beat 2, then fresh IF read with a MEM request arriving mid-read
    if_req_in = 1'b1; if_addr_in = 18'h00100;
    tick(); tick(); tick();
    check("ab_beat2_addr", ram_a_out, 18'h00102);
    if_req_in = 1'b0;
    tick();
    check("ab_no_done", if_done_out, 0);
    if_req_in = 1'b1; if_addr_in = 18'h00104;
    tick();
    check("ab_regrant", ram_a_out, 18'h00104);
    mem_cmd(1'b0, 2'b01, 18'h00106, 32'h0);
    wait_done(1'b0, 8, cyc);
    check("ab_if_cycle", cyc, 5);
    check("ab_if_data", if_data_out, 32'h12345678);
    check("ab_busy_wait", mem_busy_out, 0);
    if_req_in = 1'b0;
    tick();
    check("ab_busy_done", mem_busy_out, 0);
    tick();
    check("ab_mem_busy", mem_busy_out, 1);
    check("ab_mem_addr", ram_a_out, 18'h00106);
    wait_done(1'b1, 6, cyc);
    check("ab_half_cycle", cyc, 3);
    check("ab_half_data", mem_data_out, 32'h00001234);
    mem_req_in = 1'b0;
    tick();

    // Three-cycle stall after the first beat of a word load
    wr0 = wr_log.size();
    mem_cmd(1'b0, 2'b11, 18'h00104, 32'h0);
    tick();
    rdy_in = 1'b0;
    tick(); tick(); tick();
    check("stl_addr_hold", ram_a_out, 18'h00104);
    check("stl_wr_low", ram_wr_out, 0);
    rdy_in = 1'b1;
    tick();
    check("stl_reissue", ram_a_out, 18'h00104);
    tick();
    check("stl_next_beat", ram_a_out, 18'h00105);
    wait_done(1'b1, 8, cyc);
    check("stl_done_cycle", cyc, 4);
    check("stl_data", mem_data_out, 32'h12345678);
    mem_req_in = 1'b0;
    tick();
    check("stl_no_write", wr_log.size() - wr0, 0);

    // Reset during write beat 1, then a half store that wraps the address
    mem_cmd(1'b1, 2'b11, 18'h00300, 32'hCAFEF00D);
    tick(); tick();
    check("rw_beat1_addr", ram_a_out, 18'h00301);
    check("rw_beat1_wr", ram_wr_out, 1);
    rst_in = 1'b1;
    #1;
    check("rw_rst_wr", ram_wr_out, 0);
    check("rw_rst_addr", ram_a_out, 0);
    check("rw_rst_dout", ram_dout_out, 0);
    check("rw_rst_busy", mem_busy_out, 0);
    mem_req_in = 1'b0;
    tick();
    rst_in = 1'b0;
    tick();
    wr0 = wr_log.size();
    mem_cmd(1'b1, 2'b01, 18'h3FFFF, 32'h00001234);
    tick();
    wait_done(1'b1, 6, cyc);
    check("wrap_done_cycle", cyc, 2);
    mem_req_in = 1'b0;
    tick();
    check("wrap_beats", wr_log.size() - wr0, 2);
    check("wrap_beat0", (wr_log.size() > wr0 + 0) ? 32'(wr_log[wr0 + 0]) : 32'hFFFFFFFF, {18'h3FFFF, 8'h34});
    check("wrap_beat1", (wr_log.size() > wr0 + 1) ? 32'(wr_log[wr0 + 1]) : 32'hFFFFFFFF, {18'h00000, 8'h12});

    check("done_exclusive", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
